// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipe_pkg;

  localparam int unsigned RA_W_DEF = 32;
  localparam int unsigned PC_W_DEF = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags an ID source that depends on a load currently in EX.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] id_rs_addr,
  input  logic [RA_W-1:0] id_rt_addr,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_MemRead,
  input  logic [RA_W-1:0] ex_reg_write_addr,
  output logic            lu_c
);

  logic rs_hit;
  logic rt_hit;

  // The zero register is hard-wired, so a load targeting it never creates a dependency.
  always_comb begin
    rs_hit = id_uses_rs && (id_rs_addr == ex_reg_write_addr);
    rt_hit = id_uses_rt && (id_rt_addr == ex_reg_write_addr);
    lu_c   = ex_MemRead && (ex_reg_write_addr != RA_W'(ZERO_REG)) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing/hazard controller: load-use stall, MEM-stage redirect, memory freeze + watchdog.
// Optional stall/flush performance counters are enabled with PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RA_W        = RA_W_DEF,
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned MEM_TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs_addr,
  input  logic [RA_W-1:0] id_rt_addr,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_MemRead,
  input  logic [RA_W-1:0] ex_reg_write_addr,
  input  logic            mem_Branch,
  input  logic            mem_BranchFlip,
  input  logic            mem_Jump,
  input  logic            mem_MemRead,
  input  logic            mem_MemWrite,
  input  logic            mem_zr,
  input  logic [PC_W-1:0] mem_branch_addr,
  input  logic [PC_W-1:0] mem_jump_addr,
  input  logic            dmem_ready,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            idex_write,
  output logic            exmem_write,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            pc_sel,
  output logic [PC_W-1:0] pc_target,
  output logic            mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] count;
  logic [TMO_W-1:0] count_nxt;
  logic [TMO_W-1:0] count_inc;
  logic             err_set;
  logic             take;
  logic             mem_acc;
  logic             lu;
  logic             freeze;
  logic             resolve;

  hazard_cmp #(.RA_W(RA_W)) u_hazard_cmp (
    .id_rs_addr        (id_rs_addr),
    .id_rt_addr        (id_rt_addr),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_MemRead        (ex_MemRead),
    .ex_reg_write_addr (ex_reg_write_addr),
    .lu_c              (lu)
  );

  assign take      = mem_Jump | (mem_Branch & (mem_zr ^ mem_BranchFlip));
  assign mem_acc   = mem_MemRead | mem_MemWrite;
  assign pc_target = mem_Jump ? mem_jump_addr : mem_branch_addr;
  assign count_inc = (count == {TMO_W{1'b1}}) ? count : count + TMO_W'(1);

  // State, watchdog count and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      count   <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      mem_err <= mem_err | err_set;
    end
  end

  // Next state plus control outputs; a release cycle from MEM_WAIT resolves like RUN.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    err_set     = 1'b0;
    freeze      = 1'b0;
    resolve     = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = 1'b0;

    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_acc && !dmem_ready) begin
            freeze    = 1'b1;
            state_nxt = MEM_WAIT;
            count_nxt = TMO_W'(1);
          end else begin
            resolve = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            resolve   = 1'b1;
            state_nxt = RUN;
            count_nxt = '0;
          end else begin
            freeze    = 1'b1;
            count_nxt = count_inc;
            if (count_inc >= TMO_W'(MEM_TIMEOUT)) begin
              err_set   = 1'b1;
              state_nxt = ERR;
            end
          end
        end
        ERR: begin
          freeze = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase

      if (freeze) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
      end else if (resolve) begin
        if (take) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          pc_sel      = 1'b1;
        end else if (lu) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic stall_ev;
  logic redirect_ev;

  // A held PC outside ERR is either a load-use bubble or a memory freeze.
  assign stall_ev    = (state != ERR) && !pc_write;
  assign redirect_ev = pc_sel;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (redirect_ev && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then randomized traffic vs a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned RA_W = 32;
  localparam int unsigned PC_W = 32;
  localparam int unsigned TMO  = 5;

  logic            clk;
  logic            reset;
  logic [RA_W-1:0] id_rs_addr, id_rt_addr, ex_reg_write_addr;
  logic            id_uses_rs, id_uses_rt, ex_MemRead;
  logic            mem_Branch, mem_BranchFlip, mem_Jump, mem_MemRead, mem_MemWrite, mem_zr;
  logic [PC_W-1:0] mem_branch_addr, mem_jump_addr;
  logic            dmem_ready;
  logic            pc_write, ifid_write, idex_write, exmem_write;
  logic            ifid_flush, idex_flush, exmem_flush, pc_sel;
  logic [PC_W-1:0] pc_target;
  logic            mem_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [15:0]     stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.RA_W(RA_W), .PC_W(PC_W), .TMO_W(8), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_reg_write_addr(ex_reg_write_addr),
    .mem_Branch(mem_Branch), .mem_BranchFlip(mem_BranchFlip), .mem_Jump(mem_Jump),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_zr(mem_zr),
    .mem_branch_addr(mem_branch_addr), .mem_jump_addr(mem_jump_addr),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_sel(pc_sel), .pc_target(pc_target), .mem_err(mem_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: "waiting" = a memory access has been outstanding for wait_len frozen cycles.
  bit m_waiting = 0;
  int m_wait_len = 0;
  bit m_err = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  logic [7:0] dut_ctl;
  assign dut_ctl = {pc_write, ifid_write, idex_write, exmem_write,
                    ifid_flush, idex_flush, exmem_flush, pc_sel};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_take();
    return mem_Jump || (mem_Branch && (mem_zr != mem_BranchFlip));
  endfunction

  function automatic bit m_lu();
    bit dep;
    dep = (id_uses_rs && id_rs_addr == ex_reg_write_addr) ||
          (id_uses_rt && id_rt_addr == ex_reg_write_addr);
    return ex_MemRead && (ex_reg_write_addr != 0) && dep;
  endfunction

  function automatic bit m_frozen();
    bit acc;
    acc = mem_MemRead || mem_MemWrite;
    if (m_err) return 1'b1;
    if (m_waiting) return !dmem_ready;
    return acc && !dmem_ready;
  endfunction

  // Expected control vector {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f, pc_sel}.
  function automatic logic [7:0] m_ctl();
    if (reset)      return 8'b1111_1110;
    if (m_frozen()) return 8'b0000_0000;
    if (m_take())   return 8'b1111_1111;
    if (m_lu())     return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  task automatic model_edge();
    logic [7:0] c;
    c = m_ctl();
    if (!reset) begin
      if (!m_err && c[7] == 1'b0) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : m_stalls;
      if (c[0]) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : m_flushes;
    end
    if (reset) begin
      m_waiting = 0; m_wait_len = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else if (!m_err) begin
      if (!m_waiting) begin
        if ((mem_MemRead || mem_MemWrite) && !dmem_ready) begin
          m_waiting = 1; m_wait_len = 1;
        end
      end else if (dmem_ready) begin
        m_waiting = 0;
      end else begin
        m_wait_len++;
        if (m_wait_len >= TMO) begin
          m_err = 1; m_waiting = 0;
        end
      end
    end
  endtask

  // Compare mid-cycle, then let the clock edge advance DUT and model together.
  task automatic step(input string tag);
    logic [7:0] e;
    @(negedge clk);
    e = m_ctl();
    chk({tag, ".ctl"}, 64'(dut_ctl), 64'(e));
    chk({tag, ".mem_err"}, 64'(mem_err), 64'(m_err));
    if (e[0]) chk({tag, ".pc_target"}, 64'(pc_target), 64'(mem_Jump ? mem_jump_addr : mem_branch_addr));
`ifdef PIPE_HAZARD_PERF_EN
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stalls));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flushes));
`endif
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0;
    id_rs_addr = '0; id_rt_addr = '0; id_uses_rs = 0; id_uses_rt = 0;
    ex_MemRead = 0; ex_reg_write_addr = '0;
    mem_Branch = 0; mem_BranchFlip = 0; mem_Jump = 0; mem_MemRead = 0; mem_MemWrite = 0;
    mem_zr = 0; mem_branch_addr = '0; mem_jump_addr = '0; dmem_ready = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    step("reset0");
    step("reset1");
    reset = 0;
    step("idle");

    // Load-use on rs: one bubble, then normal flow
    ex_MemRead = 1; ex_reg_write_addr = 32'd3; id_rs_addr = 32'd3; id_uses_rs = 1;
    @(negedge clk);
    chk("lu.explicit", 64'(dut_ctl), 64'(8'b0011_0100));
    step("lu");
    clear_inputs();
    step("lu_after");

    // Memory wait: three frozen cycles, release on the fourth
    mem_MemRead = 1; dmem_ready = 0;
    step("mwait1"); step("mwait2"); step("mwait3");
    dmem_ready = 1;
    step("mrelease");
    clear_inputs();
    @(negedge clk);
    chk("mrun.explicit", 64'(dut_ctl), 64'(8'b1111_0000));
    chk("mrun.mem_err", 64'(mem_err), 64'(0));
    step("mrun");
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf.stall4", 64'(stall_cnt), 64'(4));
    chk("perf.flush0", 64'(flush_cnt), 64'(0));
`endif

    // Branch taken / not taken
    mem_Branch = 1; mem_zr = 1; mem_branch_addr = 32'h40;
    @(negedge clk);
    chk("br.target", 64'(pc_target), 64'(32'h40));
    step("br_taken");
    mem_zr = 0;
    step("br_not_taken");
    mem_BranchFlip = 1;
    step("br_flip_taken");
    clear_inputs();

    // Jump overrides a simultaneous load-use; load into r0 never stalls
    mem_Jump = 1; mem_jump_addr = 32'h10; mem_branch_addr = 32'h99;
    ex_MemRead = 1; ex_reg_write_addr = 32'd5; id_rt_addr = 32'd5; id_uses_rt = 1;
    @(negedge clk);
    chk("jmp.target", 64'(pc_target), 64'(32'h10));
    step("jmp_lu");
    clear_inputs();
    ex_MemRead = 1; ex_reg_write_addr = '0; id_rs_addr = '0; id_uses_rs = 1;
    step("lu_r0");
    clear_inputs();

    // Access completing in the same cycle causes no wait
    mem_MemWrite = 1; dmem_ready = 1;
    step("acc_ready");
    clear_inputs();

    // Release cycle honours a load-use
    mem_MemRead = 1; dmem_ready = 0;
    step("rl_wait");
    dmem_ready = 1; ex_MemRead = 1; ex_reg_write_addr = 32'd7; id_rt_addr = 32'd7; id_uses_rt = 1;
    step("rl_release_lu");
    clear_inputs();

    // Watchdog: ready held low until the error sets, stays frozen, reset recovers
    mem_MemRead = 1; dmem_ready = 0;
    for (int i = 0; i < TMO; i++) step("tmo_wait");
    @(negedge clk);
    chk("tmo.mem_err", 64'(mem_err), 64'(1));
    chk("tmo.frozen", 64'(dut_ctl), 64'(8'b0000_0000));
    dmem_ready = 1; mem_Jump = 1;
    step("err_hold");
    reset = 1;
    step("err_reset");
    clear_inputs();
    @(negedge clk);
    chk("post_reset.mem_err", 64'(mem_err), 64'(0));
    step("post_reset");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 99) < 2);
      id_rs_addr        = RA_W'($urandom_range(0, 3));
      id_rt_addr        = RA_W'($urandom_range(0, 3));
      ex_reg_write_addr = RA_W'($urandom_range(0, 3));
      id_uses_rs        = 1'($urandom);
      id_uses_rt        = 1'($urandom);
      ex_MemRead        = 1'($urandom);
      mem_Branch        = ($urandom_range(0, 3) == 0);
      mem_BranchFlip    = 1'($urandom);
      mem_zr            = 1'($urandom);
      mem_Jump          = ($urandom_range(0, 7) == 0);
      mem_MemRead       = ($urandom_range(0, 4) == 0);
      mem_MemWrite      = ($urandom_range(0, 6) == 0);
      mem_branch_addr   = PC_W'($urandom);
      mem_jump_addr     = PC_W'($urandom);
      dmem_ready        = ($urandom_range(0, 9) < 6);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing/hazard controller for the 5-stage 8-bit pipeline.
- Drives write-enable and flush for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards in ID and resolves branch/jump redirect in MEM.
- Freezes the pipeline while data memory is busy, with a timeout watchdog.
- Flush outputs are OR'd into each pipeline register's clear input. A flushed register loads all-zero, which is a bubble.

Parameters:
- RA_W, 32: register-address width, matching the pipeline register address fields.
- PC_W, 32: program-counter and branch/jump target width.
- TMO_W, 8: width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200: maximum consecutive wait cycles before the error flag sets; must fit in TMO_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_rs_addr  in  RA_W  source register 1 of the instruction in ID
- id_rt_addr  in  RA_W  source register 2 of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_MemRead  in  1  instruction in EX is a load
- ex_reg_write_addr  in  RA_W  destination register of the EX instruction
- mem_Branch  in  1  MEM-stage branch control
- mem_BranchFlip  in  1  MEM-stage branch polarity control
- mem_Jump  in  1  MEM-stage jump control
- mem_MemRead  in  1  MEM-stage load control
- mem_MemWrite  in  1  MEM-stage store control
- mem_zr  in  1  MEM-stage zero flag
- mem_branch_addr  in  PC_W  MEM-stage branch target
- mem_jump_addr  in  PC_W  MEM-stage jump target
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  register clear requests
- pc_sel  out  1  1 selects pc_target over PC+1
- pc_target  out  PC_W  redirect address
- mem_err  out  1  sticky memory-timeout error

Behaviour:
- Derived signals:
  - take = mem_Jump | (mem_Branch & (mem_zr ^ mem_BranchFlip))
  - mem_acc = mem_MemRead | mem_MemWrite
  - lu = ex_MemRead & ex_reg_write_addr != 0 & ((id_uses_rs & id_rs_addr == ex_reg_write_addr) | (id_uses_rt & id_rt_addr == ex_reg_write_addr))
- pc_target: mem_jump_addr when mem_Jump is set, otherwise mem_branch_addr. It is meaningful only while pc_sel=1.
- FSM states: RUN, MEM_WAIT, ERR. State is registered; outputs are combinational from state and inputs.
- Reset:
  - state=RUN, timeout count=0, mem_err=0.
  - While reset=1, all write enables are 1, all flushes are 1, pc_sel=0.
- RUN, priority order:
  1. mem_acc & !dmem_ready: all four write enables 0, no flush, pc_sel=0. Next state MEM_WAIT, count=1.
  2. take: all write enables 1, ifid/idex/exmem flush=1, pc_sel=1. A redirect overrides a simultaneous lu, so no stall is asserted.
  3. lu: pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1. This gives exactly one bubble.
  4. Otherwise: all enables 1, all flushes 0.
- MEM_WAIT:
  - Freeze outputs as in RUN priority 1.
  - count increments each cycle.
  - dmem_ready=1: this cycle is evaluated exactly as RUN priorities 2-4, and next state is RUN. take and lu are both honoured on the release cycle.
  - count reaches MEM_TIMEOUT with no ready: mem_err<=1, next state ERR.
- ERR:
  - Pipeline stays frozen.
  - Only reset leaves this state. Reset mid-wait or in ERR returns to RUN on the next edge.
- Boundaries:
  - Register 0 never causes a load-use stall.
  - mem_acc with dmem_ready=1 in the same cycle causes no wait.
  - The counter saturates and never wraps.

Optional Feature:
- Macro PIPE_HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt[15:0]: counts load-use stall cycles plus memory-freeze cycles.
  - flush_cnt[15:0]: counts redirect events.
- Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, MEM_WAIT, ERR} with 2-bit encoding
  - RA_W and PC_W defaults
  - ZERO_REG constant
- One natural sub-module: hazard_cmp, the combinational load-use comparator that produces lu, instantiated once. Everything else stays inline.

Test Plan:
1. Load r3 in EX, ID reads rs=3 with id_uses_rs=1 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle all enables 1.
2. mem_Branch=1, mem_BranchFlip=0, mem_zr=1, mem_branch_addr=0x40 -> pc_sel=1, pc_target=0x40, three flushes for one cycle. Repeat with mem_zr=0 -> no redirect.
3. mem_MemRead=1, dmem_ready low 3 cycles then high -> write enables 0 for 3 cycles, state returns to RUN on the 4th, mem_err stays 0.
4. MEM_TIMEOUT=5 with dmem_ready held low -> mem_err=1 after 5 wait cycles, pipeline stays frozen, reset clears everything.
5. Jump and load-use in the same cycle, mem_jump_addr=0x10 -> redirect to 0x10 with no stall. A load-use with ex_reg_write_addr=0 -> no stall.
6. With PIPE_HAZARD_PERF_EN: run scenarios 1 and 3 -> stall_cnt=4, flush_cnt=0; reset -> both counters 0.
